// File: rtl/fifo_top.sv
// Single-clock synchronous FIFO with registered read data and count-derived
// full/empty flags. DEPTH must be a power of two so the pointers wrap naturally.
module fifo_top #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  do_read;
  logic                  do_write;

  // A read frees a slot on the same edge, so a full FIFO still takes a write
  // when it is also being read.
  assign do_read  = rd_en && !empty;
  assign do_write = wr_en && (!full || do_read);

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_read) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        data_out <= mem[rd_ptr];
      end
      case ({do_write, do_read})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_top.sv
// Directed self-checking bench for fifo_top: reset, ordering, overflow,
// underflow, simultaneous access and pointer wrap.
module tb_fifo_top;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        full;
  logic        empty;

  int checks;
  int errors;

  fifo_top #(.DATA_WIDTH(32), .DEPTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of requests, then samples 1 ns after the edge.
  task automatic applyStimulus(input logic w, input logic r, input logic [31:0] d);
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  logic [31:0] basic_words [5];
  logic [31:0] last_out;
  logic [31:0] next_wr;
  logic [31:0] next_rd;
  int          mcount;
  logic        w;
  logic        r;

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;
    basic_words[0] = 32'h12153524;
    basic_words[1] = 32'hC0895E81;
    basic_words[2] = 32'h8484D609;
    basic_words[3] = 32'hB1F05663;
    basic_words[4] = 32'h06B97B0D;

    #10;
    checkOutput("rst_data_out", data_out, 32'h0);
    checkOutput("rst_empty", {31'b0, empty}, 32'h1);
    checkOutput("rst_full", {31'b0, full}, 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("rst_count", {27'b0, dut.count}, 32'h0);

    // Asynchronous reset landing between edges
    applyStimulus(1'b1, 1'b0, 32'h5555AAAA);
    applyStimulus(1'b0, 1'b1, 32'h0);
    checkOutput("pre_arst_data", data_out, 32'h5555AAAA);
    applyStimulus(1'b1, 1'b0, 32'h11112222);
    checkOutput("pre_arst_empty", {31'b0, empty}, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_empty", {31'b0, empty}, 32'h1);
    checkOutput("arst_full", {31'b0, full}, 32'h0);
    checkOutput("arst_data_out", data_out, 32'h0);
    checkOutput("arst_count", {27'b0, dut.count}, 32'h0);
    rst = 1'b0;

    // Basic ordering
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, basic_words[i]);
      if (i == 0) checkOutput("basic_empty_fall", {31'b0, empty}, 32'h0);
    end
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("basic_count", {27'b0, dut.count}, 32'h5);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h0);
      checkOutput($sformatf("basic_read%0d", i), data_out, basic_words[i]);
    end
    checkOutput("basic_empty_end", {31'b0, empty}, 32'h1);

    // Fill and overflow
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 32'(i));
      if (i == 14) checkOutput("fill_full_15", {31'b0, full}, 32'h0);
    end
    checkOutput("fill_full_16", {31'b0, full}, 32'h1);
    applyStimulus(1'b1, 1'b0, 32'hDEADBEEF);
    checkOutput("overflow_full", {31'b0, full}, 32'h1);
    checkOutput("overflow_count", {27'b0, dut.count}, 32'h10);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h0);
      checkOutput($sformatf("fill_read%0d", i), data_out, 32'(i));
    end
    checkOutput("fill_empty_end", {31'b0, empty}, 32'h1);

    // Underflow
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h0);
      checkOutput($sformatf("under_data%0d", i), data_out, 32'hF);
      checkOutput($sformatf("under_empty%0d", i), {31'b0, empty}, 32'h1);
      checkOutput($sformatf("under_count%0d", i), {27'b0, dut.count}, 32'h0);
    end

    // Simultaneous read and write while full
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 32'h100 + 32'(i));
    applyStimulus(1'b1, 1'b1, 32'hA5A5A5A5);
    checkOutput("simfull_data", data_out, 32'h100);
    checkOutput("simfull_full", {31'b0, full}, 32'h1);
    for (int i = 1; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h0);
      checkOutput($sformatf("simfull_read%0d", i), data_out, 32'h100 + 32'(i));
    end
    applyStimulus(1'b0, 1'b1, 32'h0);
    checkOutput("simfull_last", data_out, 32'hA5A5A5A5);
    checkOutput("simfull_empty", {31'b0, empty}, 32'h1);

    // Simultaneous read and write while empty: only the write happens
    applyStimulus(1'b1, 1'b1, 32'h00000077);
    checkOutput("simempty_empty", {31'b0, empty}, 32'h0);
    checkOutput("simempty_data", data_out, 32'hA5A5A5A5);
    checkOutput("simempty_count", {27'b0, dut.count}, 32'h1);
    applyStimulus(1'b0, 1'b1, 32'h0);
    checkOutput("simempty_read", data_out, 32'h00000077);
    checkOutput("simempty_drained", {31'b0, empty}, 32'h1);

    // Interleaved traffic across several pointer wraps
    next_wr  = 32'h1000;
    next_rd  = 32'h1000;
    mcount   = 0;
    last_out = 32'h00000077;
    for (int i = 0; i < 40; i++) begin
      w = ((i % 4) != 3);
      r = ((i % 2) == 1);
      applyStimulus(w, r, next_wr);
      if (r && mcount > 0) begin
        last_out = next_rd;
        next_rd++;
        mcount--;
      end
      if (w) begin
        next_wr++;
        mcount++;
      end
      checkOutput($sformatf("wrap_data%0d", i), data_out, last_out);
      checkOutput($sformatf("wrap_empty%0d", i), {31'b0, empty}, {31'b0, mcount == 0});
      checkOutput($sformatf("wrap_full%0d", i), {31'b0, full}, {31'b0, mcount == 16});
    end
    while (mcount > 0) begin
      applyStimulus(1'b0, 1'b1, 32'h0);
      checkOutput("wrap_drain", data_out, next_rd);
      next_rd++;
      mcount--;
    end
    checkOutput("wrap_all_read", next_rd, next_wr);
    checkOutput("wrap_empty_end", {31'b0, empty}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_top.md
Name: fifo_top

Overview:
Single-clock synchronous FIFO, 32-bit data path, parameterised depth. Buffers words between a producer (wr_en/data_in) and a consumer (rd_en/data_out). Reports full/empty status flags. Top-level block of the FIFO subsystem.

Parameters:
DATA_WIDTH, 32, width of data_in/data_out in bits.
DEPTH, 16, number of storage entries. Must be a power of two and at least 2.
ADDR_WIDTH, $clog2(DEPTH), width of the read/write pointers. Derived; not overridden.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
wr_en  input  1  write request, sampled on rising clk.
rd_en  input  1  read request, sampled on rising clk.
data_in  input  DATA_WIDTH  write data, captured when a write is accepted.
data_out  output  DATA_WIDTH  registered read data.
full  output  1  high when DEPTH words are stored.
empty  output  1  high when 0 words are stored.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (ports clk, rst).
  - While rst=1: write pointer, read pointer and count are 0; data_out=0; empty=1; full=0.
  - Storage array contents are not reset.
  - Assertion mid-operation discards all stored words immediately, without waiting for a clock edge.
- Write accepted on a clk edge when wr_en=1 and (full=0, or a read is accepted on the same edge).
  - data_in is stored at the write pointer.
  - Write pointer increments modulo DEPTH (wraps DEPTH-1 -> 0).
- Read accepted on a clk edge when rd_en=1 and empty=0.
  - data_out <= mem[read pointer], visible 1 cycle after the sampling edge.
  - Read pointer increments modulo DEPTH.
- data_out holds its last value when no read is accepted, including rd_en while empty.
- Write while full with no accepted read: ignored. No storage, pointer or flag change; no error output.
- Read while empty: ignored, data_out unchanged. A simultaneous write on that edge is accepted, so empty drops the next cycle.
- Simultaneous accepted read and write: both occur and count is unchanged.
  - When full, the read frees the slot, the write fills it, and full stays 1.
- Occupancy count is 0..DEPTH, width ADDR_WIDTH+1.
  - Increments on write-only, decrements on read-only, otherwise unchanged.
- Flags are registered/derived from state after the edge, with no combinational path from wr_en/rd_en.
  - empty = (count==0).
  - full = (count==DEPTH).
- Ordering is strictly first-in first-out. No data loss or duplication across pointer wrap.
- X on wr_en/rd_en is not required to be handled; the bench keeps them 0/1.

Test Plan:
- Reset: hold rst=1 for 10 ns, release -> data_out=0, empty=1, full=0. Then assert rst asynchronously mid-cycle -> flags return to reset values before the next edge.
- Basic order: write 5 words 32'h12153524, 32'hC0895E81, 32'h8484D609, 32'hB1F05663, 32'h06B97B0D on consecutive cycles, idle 8 cycles, read 5 consecutive cycles.
  - empty falls after the first write edge.
  - data_out shows the 5 words in the same order, each 1 cycle after its read edge.
  - empty=1 after the 5th read.
- Fill/overflow: write 0..15 (DEPTH=16) -> full=1 after the 16th write. A 17th write of 32'hDEAD_BEEF is ignored; reading 16 words returns 0..15 only.
- Underflow: rd_en=1 on an empty FIFO for 3 cycles -> data_out holds its previous value, empty stays 1, count stays 0.
- Simultaneous access:
  - Full FIFO, wr_en=rd_en=1 with data 32'hA5A5A5A5 -> full stays 1; oldest word emerges; 32'hA5A5A5A5 is read last.
  - Empty FIFO, wr_en=rd_en=1 -> write only, empty=0 next cycle.
- Wrap-around: 40 cycles of interleaved writes/reads with incrementing data -> read sequence strictly incrementing with no gaps across pointer wraps; flags consistent with count throughout.
